// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: loader FSM encoding, default ROM base, and a byte-reverse helper.
// Latency: none. This file holds only types, constants and pure functions.
// Backpressure: not applicable.
package rv32i;

    // Reset vector of the core, which is also word 0 of the instruction ROM.
    localparam logic [31:0] ROM_BASE_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } loader_state_e;

    // The host bridge is big-endian, so each word arrives with its byte lanes reversed.
    function automatic logic [31:0] byte_reverse32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: the host streams instruction words into ROM while the core is held in reset.
// Latency: a ROM write strobe follows acceptance by 1 cycle; the core is released HOLD_CYCLES cycles after done_in.
// Backpressure: wr_ready is high for the whole LOAD state and low otherwise; there is no stall inside LOAD.
module prog_loader
    import rv32i::*;
#(
    parameter logic [31:0] ROM_BASE    = ROM_BASE_DEFAULT,
    parameter int          ROM_WORDS   = 4096,
    parameter int          HOLD_CYCLES = 4,
    parameter bit          BYTE_SWAP   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        done_in,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        rom_we,
    output logic [31:0] rom_addr,
    output logic [31:0] rom_wdata,
    output logic        core_reset_n,
    output logic        busy,
    output logic        err,
    output logic [15:0] word_count
);

    // The hold counter only needs to reach HOLD_CYCLES-1.
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLD_CYCLES - 1);

    // The window is compared in 33 bits so that a ROM ending at 4 GiB cannot wrap.
    localparam logic [32:0] ROM_LO = {1'b0, ROM_BASE};
    localparam logic [32:0] ROM_HI = {1'b0, ROM_BASE} + (33'(ROM_WORDS) * 33'd4);

    loader_state_e  state;
    loader_state_e  state_nxt;
    logic [HCW-1:0] hold_cnt;
    logic           wr_acc;
    logic           wr_legal;

    // Decode the write handshake and check the address against the ROM window.
    always_comb begin
        wr_acc   = wr_valid & wr_ready;
        wr_legal = (wr_addr[1:0] == 2'b00)
                && ({1'b0, wr_addr} >= ROM_LO)
                && ({1'b0, wr_addr} <  ROM_HI);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. start takes priority everywhere and always (re)enters LOAD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if (start)        state_nxt = LOAD;
                else if (done_in) state_nxt = HOLD;
            end
            HOLD: begin
                if (start)                 state_nxt = LOAD;
                else if (hold_cnt == '0)   state_nxt = RUN;
            end
            RUN: begin
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded directly from the state.
    always_comb begin
        wr_ready = (state == LOAD);
        busy     = (state == LOAD) || (state == HOLD);
    end

    // Hold counter: loaded when LOAD exits on done_in and decremented through HOLD. A restart abandons it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (start) begin
            hold_cnt <= '0;
        end else if ((state == LOAD) && done_in) begin
            hold_cnt <= HOLD_INIT;
        end else if ((state == HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - HCW'(1);
        end
    end

    // The core reset is registered from the next state, so it falls on the same edge that leaves RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_reset_n <= 1'b0;
        end else begin
            core_reset_n <= (state_nxt == RUN);
        end
    end

    // Registered ROM write port. A legal aligned address already equals ROM_BASE + (word index << 2).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
        end else begin
            rom_we <= wr_acc & wr_legal;
            if (wr_acc && wr_legal) begin
                rom_addr  <= wr_addr;
                rom_wdata <= BYTE_SWAP ? byte_reverse32(wr_data) : wr_data;
            end
        end
    end

    // Download statistics: a saturating word count and a sticky drop flag, both cleared by start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err        <= 1'b0;
            word_count <= '0;
        end else if (start) begin
            err        <= 1'b0;
            word_count <= '0;
        end else if (wr_acc) begin
            if (!wr_legal) begin
                err <= 1'b1;
            end else if (word_count != 16'hFFFF) begin
                word_count <= word_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus a randomized run against a behavioural model.
// Latency: the model predicts outputs after each rising edge, and they are compared on the following falling edge.
// Backpressure: the model only accepts host writes while it is in its loading phase.
module tb_prog_loader;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;
    localparam int          HOLD  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done_in;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        rom_we;
    logic [31:0] rom_addr;
    logic [31:0] rom_wdata;
    logic        core_reset_n;
    logic        busy;
    logic        err;
    logic [15:0] word_count;

    prog_loader #(
        .ROM_BASE   (BASE),
        .ROM_WORDS  (WORDS),
        .HOLD_CYCLES(HOLD),
        .BYTE_SWAP  (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done_in     (done_in),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rom_we      (rom_we),
        .rom_addr    (rom_addr),
        .rom_wdata   (rom_wdata),
        .core_reset_n(core_reset_n),
        .busy        (busy),
        .err         (err),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: a download phase, the number of reset cycles still to go, and a running flag.
    bit          m_loading;
    bit          m_running;
    int          m_hold_rem;
    int          m_cnt;
    bit          m_err;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit legal(input logic [31:0] a);
        logic [63:0] x;
        logic [63:0] lo;
        logic [63:0] hi;
        x  = {32'd0, a};
        lo = {32'd0, BASE};
        hi = lo + 64'(4 * WORDS);
        return (a % 4 == 0) && (x >= lo) && (x < hi);
    endfunction

    function automatic logic [31:0] swap(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(3-i) +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_loading  = 1'b0;
        m_running  = 1'b0;
        m_hold_rem = 0;
        m_cnt      = 0;
        m_err      = 1'b0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
    endtask

    task automatic model_step(input bit s, input bit d, input bit v,
                              input logic [31:0] a, input logic [31:0] dd);
        m_we = 1'b0;
        if (v && m_loading) begin
            if (legal(a)) begin
                m_we    = 1'b1;
                m_addr  = a;
                m_wdata = swap(dd);
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_err = 1'b1;
            end
        end
        if (s) begin
            m_loading  = 1'b1;
            m_running  = 1'b0;
            m_hold_rem = 0;
            m_cnt      = 0;
            m_err      = 1'b0;
        end else if (m_loading && d) begin
            m_loading  = 1'b0;
            m_hold_rem = HOLD;
        end else if (m_hold_rem > 0) begin
            m_hold_rem--;
            if (m_hold_rem == 0) m_running = 1'b1;
        end
    endtask

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rom_we", 32'(rom_we), 32'(m_we));
            if (m_we) begin
                chk("rom_addr", rom_addr, m_addr);
                chk("rom_wdata", rom_wdata, m_wdata);
            end
            chk("wr_ready", 32'(wr_ready), 32'(m_loading));
            chk("busy", 32'(busy), 32'(m_loading || (m_hold_rem > 0)));
            chk("core_reset_n", 32'(core_reset_n), 32'(m_running));
            chk("err", 32'(err), 32'(m_err));
            chk("word_count", 32'(word_count), 32'(m_cnt));
        end
    end

    task automatic cycle(input bit s, input bit d, input bit v,
                         input logic [31:0] a, input logic [31:0] dd);
        start    = s;
        done_in  = d;
        wr_valid = v;
        wr_addr  = a;
        wr_data  = dd;
        @(posedge clk);
        model_step(s, d, v, a, dd);
        @(negedge clk);
        start    = 1'b0;
        done_in  = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rom_we"}, 32'(rom_we), 32'd0);
        chk({tag, "_rom_addr"}, rom_addr, 32'd0);
        chk({tag, "_rom_wdata"}, rom_wdata, 32'd0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_core_reset_n"}, 32'(core_reset_n), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] legal_a;
        legal_a = BASE + (32'($urandom_range(0, WORDS - 1)) << 2);
        case ($urandom_range(0, 7))
            0:       return 32'h8000_3FFC;
            1:       return 32'h8000_4000;
            2:       return 32'h7FFF_FFFC;
            3:       return legal_a | 32'($urandom_range(1, 3));
            4:       return $urandom();
            default: return legal_a;
        endcase
    endfunction

    initial begin
        int n_low;
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        done_in  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        reset  = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Three boot words go in and come out byte-swapped.
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, BASE + 32'(4 * i), 32'h1300_0000);
            chk("boot_we", 32'(rom_we), 32'd1);
            chk("boot_wdata", rom_wdata, 32'h0000_0013);
            chk("boot_addr", rom_addr, BASE + 32'(4 * i));
        end
        idle(1);
        chk("boot_count", 32'(word_count), 32'd3);
        chk("boot_err", 32'(err), 32'd0);

        // done_in holds the core in reset for exactly HOLD cycles.
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        n_low = 0;
        n     = 0;
        while (busy && n < 20) begin
            if (!core_reset_n) n_low++;
            n++;
            idle(1);
        end
        chk("hold_low_cycles", 32'(n_low), 32'd4);
        chk("hold_busy_fall", 32'(busy), 32'd0);
        chk("hold_release", 32'(core_reset_n), 32'd1);
        idle(2);

        // start from RUN drops the core reset on the same edge.
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("restart_core_reset_n", 32'(core_reset_n), 32'd0);
        chk("restart_count", 32'(word_count), 32'd0);
        chk("restart_wr_ready", 32'(wr_ready), 32'd1);

        // Misaligned, below-window and past-window writes are all dropped.
        cycle(1'b0, 1'b0, 1'b1, 32'h8000_0002, 32'h1111_1111);
        chk("drop_misaligned", 32'(rom_we), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h7FFF_FFFC, 32'h2222_2222);
        chk("drop_below", 32'(rom_we), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h8000_4000, 32'h3333_3333);
        chk("drop_above", 32'(rom_we), 32'd0);
        idle(1);
        chk("drop_err", 32'(err), 32'd1);
        chk("drop_count", 32'(word_count), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("start_clears_err", 32'(err), 32'd0);

        // A write and done_in in the same cycle: the write lands on the first HOLD cycle.
        cycle(1'b0, 1'b1, 1'b1, 32'h8000_0010, 32'hAABB_CCDD);
        chk("last_we", 32'(rom_we), 32'd1);
        chk("last_wdata", rom_wdata, 32'hDDCC_BBAA);
        chk("last_count", 32'(word_count), 32'd1);
        chk("last_busy", 32'(busy), 32'd1);
        chk("last_wr_ready", 32'(wr_ready), 32'd0);
        idle(6);

        // Randomized traffic. start is never combined with a write in the same cycle.
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 3000; k++) begin
            bit s;
            bit d;
            bit v;
            if (m_hold_rem > 0)  s = ($urandom_range(0, 3) == 0);
            else if (m_running)  s = ($urandom_range(0, 19) == 0);
            else                 s = ($urandom_range(0, 199) == 0);
            d = ($urandom_range(0, 39) == 0);
            v = !s && ($urandom_range(0, 9) < 6);
            cycle(s, d, v, rand_addr(), $urandom());
        end

        // Asynchronous reset from RUN with err and the count both set.
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, BASE + 32'h20, 32'h0BAD_F00D);
        cycle(1'b0, 1'b0, 1'b1, 32'h8000_0001, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        idle(6);
        chk("pre_rst_run", 32'(core_reset_n), 32'd1);
        chk("pre_rst_err", 32'(err), 32'd1);
        chk("pre_rst_count", 32'(word_count), 32'd1);
        #2;
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk_reset_outputs("async_run");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk_en = 1'b1;

        // Reset between acceptance and the registering edge: the pending write must vanish.
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        wr_valid = 1'b1;
        wr_addr  = BASE + 32'h40;
        wr_data  = 32'h1234_5678;
        #2;
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk_reset_outputs("async_load");
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pending_we_dropped", 32'(rom_we), 32'd0);
        @(negedge clk);
        chk("pending_we_still_low", 32'(rom_we), 32'd0);
        reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
